// File: rtl/add_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// add_share_arbiter_pkg : adder geometry and arbiter state encoding
// Revision: 1.0
// ============================================================================
package add_share_arbiter_pkg;

  localparam int ADD_WIDTH   = 3328;
  localparam int ADD_LIMB    = 256;
  localparam int ADD_LIMBS   = 13;
  localparam int ADD_LATENCY = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/add_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// add_share_arbiter_rr_pick : combinational round-robin picker (first set bit from ptr, wrapping)
// Revision: 1.0
// ============================================================================
module add_share_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = |req;
    // Scan from the far end so the candidate closest to ptr is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_share_arbiter.sv
`default_nettype none
// ============================================================================
// add_share_arbiter : shares one wide multi-cycle adder among NUM_REQ requesters
// Revision: 1.0
// ============================================================================
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ADD_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_carry,
  output logic                     err_timeout,
  output logic                     add_rst_n,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_en,
  input  logic [WIDTH-1:0]         add_c,
  input  logic                     add_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_grant_fire;

  add_share_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  assign w_next_ptr   = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
  // An accept shown during reset would be a lie: nothing is latched that edge.
  assign w_grant_fire = (r_state == ST_IDLE) && w_pick_any && !rst;
  assign req_ready    = w_grant_fire ? w_pick_grant : '0;
  assign resp_valid   = (r_state == ST_RESP) ? (NUM_REQ'(1) << r_owner) : '0;
  assign add_en       = (r_state == ST_ISSUE);
  assign add_rst_n    = ~rst;
  assign resp_carry   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_wait_cnt  <= '0;
      err_timeout <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      resp_sum    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            add_a    <= req_a[int'(w_pick_idx)*WIDTH +: WIDTH];
            add_b    <= req_b[int'(w_pick_idx)*WIDTH +: WIDTH];
            r_owner  <= w_pick_idx;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (add_done) begin
            resp_sum <= add_c;
            r_state  <= ST_RESP;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (resp_ready[r_owner]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_add_share_arbiter : randomized self-checking bench with a behavioural adder and arbiter model
// Revision: 1.0
// ============================================================================
module tb_add_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 3328;
  localparam int TIMEOUT = 15;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]       req_ready, resp_valid, resp_ready;
  logic [WIDTH-1:0]         resp_sum, add_a, add_b, add_c;
  logic                     resp_carry, err_timeout, add_rst_n, add_en, add_done;

  always #5 clk = ~clk;

  add_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_carry(resp_carry), .err_timeout(err_timeout),
    .add_rst_n(add_rst_n), .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_c(add_c), .add_done(add_done)
  );

  // Adder model: done pulse 3 cycles after the start pulse, cleared by its reset.
  int               dly = 0;
  logic [WIDTH-1:0] model_sum = '0;
  logic             suppress = 1'b0;
  logic             spur = 1'b0;

  always @(posedge clk) begin
    if (!add_rst_n) dly <= 0;
    else if (add_en) begin
      dly       <= 3;
      model_sum <= add_a + add_b;
    end else if (dly > 0) dly <= dly - 1;
  end
  assign add_done = ((dly == 1) && !suppress) || spur;
  assign add_c    = model_sum;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int ref_pick(input logic [NUM_REQ-1:0] m, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int first_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Waits for a grant, then follows the operation until resp_valid appears.
  task automatic serve(input bit drop, output int g, output int en_lat, output int en_cnt,
                       output int resp_lat, output logic [NUM_REQ-1:0] rv,
                       output logic [WIDTH-1:0] sum, output bit held);
    logic [WIDTH-1:0] opa, opb;
    g = -1; en_lat = -1; en_cnt = 0; resp_lat = -1; rv = '0; sum = '0; held = 1'b1;
    #1;
    for (int t = 0; t < 30; t++) begin
      if (|req_ready) begin
        g = first_idx(req_ready);
        break;
      end
      cyc();
    end
    if (g < 0) return;
    cyc();
    if (drop) req_valid[g] = 1'b0;
    opa = add_a;
    opb = add_b;
    for (int rel = 1; rel <= 40; rel++) begin
      if (add_en) begin
        en_cnt++;
        if (en_lat < 0) en_lat = rel;
      end
      if (add_a !== opa || add_b !== opb) held = 1'b0;
      if (|resp_valid) begin
        resp_lat = rel;
        rv  = resp_valid;
        sum = resp_sum;
        break;
      end
      cyc();
    end
  endtask

  task automatic accept(input int g);
    resp_ready    = '0;
    resp_ready[g] = 1'b1;
    cyc();
    resp_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; resp_ready = '0;
    cyc(); cyc();
    checks++; if (req_ready !== '0 || resp_valid !== '0 || add_en !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: req_ready=%b resp_valid=%b add_en=%b want 0", req_ready, resp_valid, add_en); end
    checks++; if (add_a !== '0 || add_b !== '0 || resp_sum !== '0) begin
      errors++; $display("FAIL reset_data: add_a[63:0]=%h add_b[63:0]=%h sum[63:0]=%h want 0", add_a[63:0], add_b[63:0], resp_sum[63:0]); end
    checks++; if (err_timeout !== 1'b0 || resp_carry !== 1'b0 || add_rst_n !== 1'b0) begin
      errors++; $display("FAIL reset_flags: err=%b carry=%b add_rst_n=%b want 0 0 0", err_timeout, resp_carry, add_rst_n); end
    rst = 1'b0;
    #1;
    checks++; if (add_rst_n !== 1'b1) begin
      errors++; $display("FAIL reset_release: add_rst_n=%b want 1", add_rst_n); end
    model_ptr = 0;
  endtask

  task automatic test_single();
    int g, el, ec, rl; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s; bit held;
    set_ops(2, '1, WIDTH'(1));
    req_valid = 4'b0100;
    serve(1'b1, g, el, ec, rl, rv, s, held);
    model_ptr = 3;
    checks++; if (g !== 2) begin errors++; $display("FAIL single_grant: got %0d want 2", g); end
    checks++; if (el !== 1 || ec !== 1) begin
      errors++; $display("FAIL single_en: latency %0d count %0d want 1 1", el, ec); end
    checks++; if (rl !== 5 || rv !== 4'b0100) begin
      errors++; $display("FAIL single_resp: latency %0d valid %b want 5 0100", rl, rv); end
    checks++; if (s !== '0 || resp_carry !== 1'b0) begin
      errors++; $display("FAIL single_sum: sum[63:0]=%h carry=%b want 0 0", s[63:0], resp_carry); end
    checks++; if (!held) begin errors++; $display("FAIL single_hold: operands changed in flight got 0 want 1"); end
    accept(2);
    checks++; if (resp_valid !== '0) begin
      errors++; $display("FAIL single_accept: resp_valid=%b want 0000", resp_valid); end
  endtask

  task automatic test_round_robin();
    int g, el, ec, rl, exp; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s; bit held;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, WIDTH'(i), WIDTH'(100));
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      exp = ref_pick(req_valid, model_ptr);
      serve(1'b0, g, el, ec, rl, rv, s, held);
      checks++; if (g !== exp) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", n, g, exp); end
      checks++; if (rv !== (NUM_REQ'(1) << exp) || s !== WIDTH'(100 + exp)) begin
        errors++; $display("FAIL rr_resp%0d: valid %b sum[63:0]=%h want %b %h", n, rv, s[63:0], NUM_REQ'(1) << exp, 100 + exp); end
      model_ptr = (exp + 1) % NUM_REQ;
      if (g >= 0) accept(g);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, el, ec, rl, exp; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s, es; bit held;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, rand_wide(), rand_wide());
      req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      exp = ref_pick(req_valid, model_ptr);
      es  = req_a[exp*WIDTH +: WIDTH] + req_b[exp*WIDTH +: WIDTH];
      serve(1'b0, g, el, ec, rl, rv, s, held);
      checks++; if (g !== exp || rv !== (NUM_REQ'(1) << exp)) begin
        errors++; $display("FAIL rand_grant%0d: got %0d valid %b want %0d", n, g, rv, exp); end
      checks++; if (s !== es) begin
        errors++; $display("FAIL rand_sum%0d: sum[63:0]=%h want %h", n, s[63:0], es[63:0]); end
      checks++; if (ec !== 1 || rl !== 5 || !held) begin
        errors++; $display("FAIL rand_timing%0d: en %0d resp_lat %0d held %0d want 1 5 1", n, ec, rl, held); end
      model_ptr = (exp + 1) % NUM_REQ;
      repeat ($urandom_range(0, 3)) cyc();
      if (g >= 0) accept(g);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g, el, ec, rl, exp; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s, es; bit held;
    int bad;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, rand_wide(), rand_wide());
    es = req_a[WIDTH +: WIDTH] + req_b[WIDTH +: WIDTH];
    req_valid = 4'b0010;
    serve(1'b1, g, el, ec, rl, rv, s, held);
    model_ptr = 2;
    checks++; if (g !== 1 || s !== es) begin
      errors++; $display("FAIL bp_first: grant %0d sum[63:0]=%h want 1 %h", g, s[63:0], es[63:0]); end
    req_valid  = '1;
    resp_ready = 4'b1101;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (resp_valid !== 4'b0010 || resp_sum !== es || add_en !== 1'b0 || req_ready !== '0) bad++;
      cyc();
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles want 0 (valid %b)", bad, resp_valid); end
    accept(1);
    exp = ref_pick(req_valid, model_ptr);
    es  = req_a[exp*WIDTH +: WIDTH] + req_b[exp*WIDTH +: WIDTH];
    serve(1'b0, g, el, ec, rl, rv, s, held);
    checks++; if (g !== exp || s !== es) begin
      errors++; $display("FAIL bp_next: grant %0d sum[63:0]=%h want %0d %h", g, s[63:0], exp, es[63:0]); end
    model_ptr = (exp + 1) % NUM_REQ;
    req_valid = '0;
    if (g >= 0) accept(g);
  endtask

  task automatic test_timeout();
    int g, el, ec, rl, err_rel; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s, es; bit held, saw;
    checks++; if (err_timeout !== 1'b0) begin
      errors++; $display("FAIL to_pre: err_timeout=%b want 0", err_timeout); end
    suppress = 1'b1;
    set_ops(0, rand_wide(), rand_wide());
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL to_grant: req_ready=%b want 0001", req_ready); end
    cyc();
    req_valid = '0;
    model_ptr = 1;
    err_rel = -1; saw = 1'b0;
    for (int rel = 1; rel <= 40; rel++) begin
      if (err_timeout) begin err_rel = rel; break; end
      if (|resp_valid) saw = 1'b1;
      cyc();
    end
    checks++; if (err_rel !== TIMEOUT + 2 || saw) begin
      errors++; $display("FAIL to_err: err at %0d resp_seen %0d want %0d 0", err_rel, saw, TIMEOUT + 2); end
    #1;
    checks++; if (resp_valid !== '0 || add_en !== 1'b0) begin
      errors++; $display("FAIL to_idle: resp_valid=%b add_en=%b want 0", resp_valid, add_en); end
    suppress = 1'b0;
    set_ops(3, rand_wide(), rand_wide());
    es = req_a[3*WIDTH +: WIDTH] + req_b[3*WIDTH +: WIDTH];
    req_valid = 4'b1000;
    serve(1'b1, g, el, ec, rl, rv, s, held);
    model_ptr = 0;
    checks++; if (g !== 3 || s !== es || rl !== 5 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL to_recover: grant %0d lat %0d err %b sum[63:0]=%h want 3 5 1 %h", g, rl, err_timeout, s[63:0], es[63:0]); end
    if (g >= 0) accept(g);
  endtask

  task automatic test_reset_mid_wait();
    int g, el, ec, rl, bad; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s, es; bit held;
    set_ops(2, rand_wide(), rand_wide());
    req_valid = 4'b0100;
    #1;
    cyc();
    req_valid = '0;
    checks++; if (add_en !== 1'b1) begin
      errors++; $display("FAIL rw_issue: add_en=%b want 1", add_en); end
    cyc();
    rst = 1'b1;
    #1;
    checks++; if (add_rst_n !== 1'b0) begin
      errors++; $display("FAIL rw_add_rst: add_rst_n=%b want 0", add_rst_n); end
    cyc();
    rst = 1'b0;
    model_ptr = 0;
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      if (resp_valid !== '0 || add_en !== 1'b0) bad++;
      cyc();
    end
    checks++; if (bad !== 0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL rw_quiet: %0d active cycles err %b want 0 0", bad, err_timeout); end
    set_ops(1, rand_wide(), rand_wide());
    set_ops(3, rand_wide(), rand_wide());
    es = req_a[WIDTH +: WIDTH] + req_b[WIDTH +: WIDTH];
    req_valid = 4'b1010;
    serve(1'b0, g, el, ec, rl, rv, s, held);
    checks++; if (g !== 1 || s !== es || rl !== 5) begin
      errors++; $display("FAIL rw_next: grant %0d lat %0d sum[63:0]=%h want 1 5 %h", g, rl, s[63:0], es[63:0]); end
    model_ptr = 2;
    req_valid = '0;
    if (g >= 0) accept(g);
  endtask

  task automatic test_spurious_done();
    int g, el, ec, rl, bad, exp; logic [NUM_REQ-1:0] rv; logic [WIDTH-1:0] s, es; bit held;
    req_valid = '0;
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    bad = 0;
    for (int t = 0; t < 4; t++) begin
      if (resp_valid !== '0 || add_en !== 1'b0 || req_ready !== '0) bad++;
      cyc();
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL spur_idle: %0d active cycles want 0", bad); end
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, rand_wide(), rand_wide());
    req_valid = 4'b1001;
    exp = ref_pick(req_valid, model_ptr);
    es  = req_a[exp*WIDTH +: WIDTH] + req_b[exp*WIDTH +: WIDTH];
    serve(1'b1, g, el, ec, rl, rv, s, held);
    checks++; if (g !== exp || s !== es || el !== 1 || rl !== 5) begin
      errors++; $display("FAIL spur_next: grant %0d en %0d lat %0d sum[63:0]=%h want %0d 1 5 %h", g, el, rl, s[63:0], exp, es[63:0]); end
    model_ptr = (exp + 1) % NUM_REQ;
    req_valid = '0;
    if (g >= 0) accept(g);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_spurious_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
